delayed_exec_pipe: RTL and testbench
====================================

DELAYED_EXEC_PIPE -- requirements
Module: delayed_exec_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width in bits; legal values are 32 and 64.
REQ-002 Parameter LANES, default 2, SHALL set the number of independent ALU lanes; legal range is 1..4.
REQ-003 Parameter STAGES, default 2, SHALL set the number of register stages from input to output; legal range is 1..4.
REQ-004 Local SHW SHALL equal log2(DATA_WIDTH).
REQ-005 clk  input  1  SHALL be the single clock; every flop updates on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 flush  input  1  SHALL discard all in-flight entries.
REQ-008 in_valid  input  1  SHALL mark that an issue group is presented.
REQ-009 in_ready  output  1  SHALL mark that the block accepts the group this cycle.
REQ-010 in_lane_en  input  LANES  SHALL be the per-lane enable within the group.
REQ-011 in_op  input  LANES*4  SHALL carry the per-lane op code.
REQ-012 in_reg1 and in_reg2  input  LANES*DATA_WIDTH  SHALL carry the per-lane operands.
REQ-013 in_shamt  input  LANES*SHW  SHALL carry the per-lane immediate shift amount.
REQ-014 in_pass  input  LANES*DATA_WIDTH  SHALL carry the per-lane fallback result.
REQ-015 out_valid  output  1  SHALL mark that a result group is presented.
REQ-016 out_ready  input  1  SHALL mark that downstream consumes the presented group.
REQ-017 out_lane_en  output  LANES  SHALL be the lane enable travelling with the group.
REQ-018 out_result  output  LANES*DATA_WIDTH  SHALL carry the per-lane result.

Function
REQ-019 Op codes SHALL be: 0 PASS, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 ADDU, 6 SUBU, 7 SLL, 8 SRL, 9 SRA, 10 SLLV, 11 SRLV, 12 SRAV, 13 SLT, 14 SLTU, 15 CLZ.
REQ-020 Immediate shifts SHALL use in_shamt; variable shifts SHALL use reg1[SHW-1:0]; the shifted operand SHALL be reg2.
REQ-021 SLT and SLTU SHALL return the comparison bit zero-extended to the full DATA_WIDTH.
REQ-022 ADDU and SUBU SHALL wrap modulo 2^DATA_WIDTH, with no overflow indication.
REQ-023 PASS and any op not compiled in SHALL return in_pass unchanged.
REQ-024 A disabled lane SHALL still be computed, but its out_lane_en bit SHALL be 0.
REQ-025 The group SHALL be computed combinationally, then captured into stage 1 on in_valid && in_ready.
REQ-026 A group SHALL appear at the output exactly STAGES cycles after acceptance when there is no backpressure.
REQ-027 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage advances on out_ready.
REQ-028 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing), giving full throughput of one group per cycle.
REQ-029 Stall SHALL hold every valid stage's data and lane enables bit-stable.
REQ-030 out_valid SHALL depend only on registers; it SHALL never combinationally depend on in_valid.
REQ-031 On flush, all stage valid bits SHALL clear on the next edge and in_ready SHALL be 0 in that cycle; a group presented in the flush cycle SHALL be dropped.
REQ-032 Flush and rst asserted together SHALL behave as rst.

Reset
REQ-033 On rst, all stage valid bits, out_valid and out_lane_en SHALL go to 0, and in_ready SHALL be 0 during the reset cycle.
REQ-034 Data registers SHALL need no reset value; out_result SHALL be 0 while out_valid is 0.
REQ-035 Reset asserted mid-stream SHALL drop every in-flight group without emitting it.

Configuration
REQ-036 With macro DELAYED_EXEC_CLZ_EN defined, op 15 SHALL return the leading-zero count of reg1 (value DATA_WIDTH for reg1 == 0).
REQ-037 Without DELAYED_EXEC_CLZ_EN, op 15 SHALL behave as PASS and no count logic SHALL be synthesised.

Verification
REQ-038 LANES=2, STAGES=2: lane0 ADDU 0xFFFFFFFF+1, lane1 SLT 0x80000000,1 -> two cycles later results 0x0 and 0x1.
REQ-039 SRAV reg2=0x80000000, reg1=0x24 (shift 4) -> 0xF8000000; SRL shamt=31 of 0x80000000 -> 0x1.
REQ-040 out_ready held low for 3 cycles with a continuous input stream -> in_ready drops once all stages are full, no group is lost or duplicated, and the order is preserved.
REQ-041 Flush asserted while 2 groups are in flight and a third is presented -> nothing emitted afterwards; the next accepted group emerges STAGES cycles later.
REQ-042 Op 15 with reg1=0x00010000: with DELAYED_EXEC_CLZ_EN -> 15; reg1=0 -> 32; without the macro -> the in_pass value.
REQ-043 rst pulsed mid-stream -> out_valid is 0 the cycle after reset and no pre-reset group ever appears.

Source files
------------

// File: rtl/delayed_exec_pipe_if.sv
// Issue/result handshake bundle for delayed_exec_pipe.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface delayed_exec_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0]            in_lane_en;
  logic [LANES*4-1:0]          in_op;
  logic [LANES*DATA_WIDTH-1:0] in_reg1;
  logic [LANES*DATA_WIDTH-1:0] in_reg2;
  logic [LANES*SHW-1:0]        in_shamt;
  logic [LANES*DATA_WIDTH-1:0] in_pass;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0]            out_lane_en;
  logic [LANES*DATA_WIDTH-1:0] out_result;

  modport master (
    output flush, in_valid, in_lane_en, in_op, in_reg1, in_reg2, in_shamt, in_pass, out_ready,
    input  in_ready, out_valid, out_lane_en, out_result
  );

  modport slave (
    input  flush, in_valid, in_lane_en, in_op, in_reg1, in_reg2, in_shamt, in_pass, out_ready,
    output in_ready, out_valid, out_lane_en, out_result
  );
endinterface

// File: rtl/delayed_exec_pipe.sv
// Multi-lane ALU feeding a STAGES-deep elastic register pipeline.
// Define DELAYED_EXEC_CLZ_EN to compile in the op-15 leading-zero count.
module delayed_exec_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  delayed_exec_pipe_if.slave    bus
);
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_PASS, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADDU, OP_SUBU, OP_SLL,
    OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_SLT, OP_SLTU, OP_CLZ
  } op_e;

  logic [LANES*DATA_WIDTH-1:0] alu_res;
  logic [STAGES-1:0]           vld_q, vld_d;
  logic [STAGES-1:0]           can_acc;
  logic [LANES-1:0]            lane_q [STAGES];
  logic [LANES*DATA_WIDTH-1:0] data_q [STAGES];
  logic                        acc_in;

  always_comb begin
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] a, b, p, res;
    logic [SHW-1:0]        sh_imm, sh_var;
`ifdef DELAYED_EXEC_CLZ_EN
    logic [DATA_WIDTH-1:0] clz;
`endif
    alu_res = '0;
    op      = '0;
    a       = '0;
    b       = '0;
    p       = '0;
    res     = '0;
    sh_imm  = '0;
    sh_var  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      op     = bus.in_op[l*4 +: 4];
      a      = bus.in_reg1[l*DATA_WIDTH +: DATA_WIDTH];
      b      = bus.in_reg2[l*DATA_WIDTH +: DATA_WIDTH];
      p      = bus.in_pass[l*DATA_WIDTH +: DATA_WIDTH];
      sh_imm = bus.in_shamt[l*SHW +: SHW];
      sh_var = a[SHW-1:0];
`ifdef DELAYED_EXEC_CLZ_EN
      // Highest set bit is visited last, so it sets the final count.
      clz = DATA_WIDTH'(DATA_WIDTH);
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        if (a[i]) clz = DATA_WIDTH'(DATA_WIDTH - 1 - i);
      end
`endif
      case (op)
        OP_AND:  res = a & b;
        OP_OR:   res = a | b;
        OP_XOR:  res = a ^ b;
        OP_NOR:  res = ~(a | b);
        OP_ADDU: res = a + b;
        OP_SUBU: res = a - b;
        OP_SLL:  res = b << sh_imm;
        OP_SRL:  res = b >> sh_imm;
        OP_SRA:  res = $signed(b) >>> sh_imm;
        OP_SLLV: res = b << sh_var;
        OP_SRLV: res = b >> sh_var;
        OP_SRAV: res = $signed(b) >>> sh_var;
        OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, a < b};
`ifdef DELAYED_EXEC_CLZ_EN
        OP_CLZ:  res = clz;
`endif
        default: res = p;
      endcase
      alu_res[l*DATA_WIDTH +: DATA_WIDTH] = res;
    end
  end

  // Stage k can take new data iff some stage at or after k is empty, or the
  // output is being consumed; flattened so no vector bit feeds another.
  always_comb begin
    can_acc = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      can_acc[k] = bus.out_ready;
      for (int unsigned j = k; j < STAGES; j++) begin
        if (!vld_q[j]) can_acc[k] = 1'b1;
      end
    end
  end

  assign bus.in_ready = can_acc[0] && !bus.flush && !rst;
  assign acc_in       = bus.in_valid && bus.in_ready;

  always_comb begin
    vld_d = vld_q;
    if (can_acc[0]) vld_d[0] = acc_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (can_acc[k]) vld_d[k] = vld_q[k-1];
    end
    if (bus.flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) lane_q[k] <= '0;
    end else begin
      if (can_acc[0]) lane_q[0] <= bus.in_lane_en;
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (can_acc[k]) lane_q[k] <= lane_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (can_acc[0]) data_q[0] <= alu_res;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (can_acc[k]) data_q[k] <= data_q[k-1];
    end
  end

  assign bus.out_valid   = vld_q[STAGES-1];
  assign bus.out_lane_en = vld_q[STAGES-1] ? lane_q[STAGES-1] : '0;
  assign bus.out_result  = vld_q[STAGES-1] ? data_q[STAGES-1] : '0;
endmodule

// File: tb/tb_delayed_exec_pipe.sv
// Directed bench for delayed_exec_pipe (DATA_WIDTH=32, LANES=2, STAGES=2).
module tb_delayed_exec_pipe;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int ST = 2;
  localparam int NV = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delayed_exec_pipe_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

  delayed_exec_pipe #(.DATA_WIDTH(DW), .LANES(L), .STAGES(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  sh;
    logic [31:0] pass;
    logic [31:0] exp;
  } lane_vec_t;

  lane_vec_t vec [NV];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [3:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [4:0] sh, input logic [31:0] pass);
    bus.in_op[l*4 +: 4]     = op;
    bus.in_reg1[l*32 +: 32] = r1;
    bus.in_reg2[l*32 +: 32] = r2;
    bus.in_shamt[l*5 +: 5]  = sh;
    bus.in_pass[l*32 +: 32] = pass;
  endtask

  task automatic set_id_group(input int id);
    set_lane(0, 4'd0, 32'h0, 32'h0, 5'd0, 32'(id));
    set_lane(1, 4'd0, 32'h0, 32'h0, 5'd0, 32'(id + 100));
    bus.in_lane_en = 2'b11;
  endtask

  initial begin
    int q [$];
    int next_id;
    int got;
    int e;
    bit acc;
    bit prev_stall;
    logic [63:0] prev_res;
    bit exp_rdy [10];

    vec[0]  = '{4'd0,  32'h0,        32'h0,        5'd0,  32'h12345678, 32'h12345678};
    vec[1]  = '{4'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hDEADBEEF, 32'h00F000F0};
    vec[2]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hDEADBEEF, 32'hFFF0FFF0};
    vec[3]  = '{4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hDEADBEEF, 32'hFF00FF00};
    vec[4]  = '{4'd4,  32'h0000FFFF, 32'h00FF0000, 5'd0,  32'hDEADBEEF, 32'hFF000000};
    vec[5]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'hDEADBEEF, 32'h00000000};
    vec[6]  = '{4'd6,  32'h00000000, 32'h00000001, 5'd0,  32'hDEADBEEF, 32'hFFFFFFFF};
    vec[7]  = '{4'd7,  32'h00000003, 32'h0000000F, 5'd4,  32'hDEADBEEF, 32'h000000F0};
    vec[8]  = '{4'd8,  32'h00000003, 32'h80000000, 5'd31, 32'hDEADBEEF, 32'h00000001};
    vec[9]  = '{4'd9,  32'h00000003, 32'h80000000, 5'd4,  32'hDEADBEEF, 32'hF8000000};
    vec[10] = '{4'd10, 32'h00000021, 32'h40000001, 5'd5,  32'hDEADBEEF, 32'h80000002};
    vec[11] = '{4'd11, 32'h00000024, 32'h80000000, 5'd1,  32'hDEADBEEF, 32'h08000000};
    vec[12] = '{4'd12, 32'h00000024, 32'h80000000, 5'd1,  32'hDEADBEEF, 32'hF8000000};
    vec[13] = '{4'd13, 32'h80000000, 32'h00000001, 5'd0,  32'hDEADBEEF, 32'h00000001};
    vec[14] = '{4'd14, 32'h80000000, 32'h00000001, 5'd0,  32'hDEADBEEF, 32'h00000000};
    vec[15] = '{4'd14, 32'h00000001, 32'h80000000, 5'd0,  32'hDEADBEEF, 32'h00000001};
`ifdef DELAYED_EXEC_CLZ_EN
    vec[16] = '{4'd15, 32'h00010000, 32'h0,        5'd0,  32'hCAFEBABE, 32'd15};
    vec[17] = '{4'd15, 32'h00000000, 32'h0,        5'd0,  32'h11111111, 32'd32};
`else
    vec[16] = '{4'd15, 32'h00010000, 32'h0,        5'd0,  32'hCAFEBABE, 32'hCAFEBABE};
    vec[17] = '{4'd15, 32'h00000000, 32'h0,        5'd0,  32'h11111111, 32'h11111111};
`endif

    // Reset, with a group presented during reset.
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    set_id_group(7);
    tick();
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_lane_en", {62'b0, bus.out_lane_en}, 64'd0);
    chk("rst_result", bus.out_result, 64'd0);

    // Table: each group pairs vec[i] on lane 0 with vec[NV-1-i] on lane 1.
    for (int i = 0; i < NV; i++) begin
      set_lane(0, vec[i].op, vec[i].r1, vec[i].r2, vec[i].sh, vec[i].pass);
      set_lane(1, vec[NV-1-i].op, vec[NV-1-i].r1, vec[NV-1-i].r2, vec[NV-1-i].sh, vec[NV-1-i].pass);
      bus.in_lane_en = 2'(i % 4);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), {63'b0, bus.out_valid}, 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'b0, bus.out_valid}, 64'd1);
      chk($sformatf("vec%0d_lane_en", i), {62'b0, bus.out_lane_en}, 64'(i % 4));
      chk($sformatf("vec%0d_res", i), bus.out_result, {vec[NV-1-i].exp, vec[i].exp});
      tick();
    end
    chk("idle_result_zero", bus.out_result, 64'd0);

    // ADDU wrap on lane 0, signed SLT on lane 1, both lanes enabled.
    set_lane(0, 4'd5, 32'hFFFFFFFF, 32'h1, 5'd0, 32'hDEADBEEF);
    set_lane(1, 4'd13, 32'h80000000, 32'h1, 5'd0, 32'hDEADBEEF);
    bus.in_lane_en = 2'b11;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("addu_slt_valid", {63'b0, bus.out_valid}, 64'd1);
    chk("addu_slt_res", bus.out_result, 64'h00000001_00000000);
    tick();

    // Backpressure: out_ready low for the first three cycles of a stream.
    exp_rdy = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    next_id = 1;
    got = 0;
    prev_stall = 1'b0;
    prev_res = '0;
    for (int c = 0; c < 10; c++) begin
      bus.out_ready = (c >= 3);
      set_id_group(next_id);
      bus.in_valid = 1'b1;
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), {63'b0, bus.in_ready}, 64'(exp_rdy[c]));
      acc = bus.in_ready;
      if (prev_stall) chk($sformatf("bp_hold_c%0d", c), bus.out_result, prev_res);
      if (bus.out_valid && bus.out_ready) begin
        got++;
        if (q.size() == 0) chk("bp_extra_group", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk($sformatf("bp_order_c%0d", c), bus.out_result, {32'(e + 100), 32'(e)});
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res = bus.out_result;
      tick();
      if (acc) begin
        q.push_back(next_id);
        next_id++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        got++;
        if (q.size() == 0) chk("bp_extra_group", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk($sformatf("bp_drain_%0d", c), bus.out_result, {32'(e + 100), 32'(e)});
        end
      end
      tick();
    end
    chk("bp_none_lost", 64'(q.size()), 64'd0);
    chk("bp_count", 64'(got), 64'(next_id - 1));

    // Flush with two groups held in flight and a third presented.
    bus.out_ready = 1'b0;
    set_id_group(201);
    bus.in_valid = 1'b1;
    tick();
    set_id_group(202);
    tick();
    set_id_group(203);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'b0, bus.in_ready}, 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("flush_quiet_%0d", c), {63'b0, bus.out_valid}, 64'd0);
      tick();
    end
    set_id_group(204);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post_flush_early", {63'b0, bus.out_valid}, 64'd0);
    tick();
    chk("post_flush_valid", {63'b0, bus.out_valid}, 64'd1);
    chk("post_flush_res", bus.out_result, {32'd304, 32'd204});
    tick();

    // Reset mid-stream.
    set_id_group(301);
    bus.in_valid = 1'b1;
    tick();
    set_id_group(302);
    tick();
    rst = 1'b1;
    set_id_group(303);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midrst_quiet_%0d", c), {63'b0, bus.out_valid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
